// File: rtl/plru_tree_nset.sv
// Tree pseudo-LRU replacement for SETS independent sets of WAYS ways, invalid-first victim choice, 1-cycle registered victim.
// Optional way locking when PLRU_WAY_LOCK_EN is defined (adds lock_mask input, enables victim_none).
module plru_tree_nset #(
    parameter int WAYS = 16,
    parameter int SETS = 4,
    localparam int WW = $clog2(WAYS),
    localparam int SW = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            acc_valid,
    input  logic [SW-1:0]   acc_set,
    input  logic            acc_hit,
    input  logic [WW-1:0]   acc_hit_way,
    input  logic            inv_valid,
    input  logic [SW-1:0]   inv_set,
    input  logic [WW-1:0]   inv_way,
`ifdef PLRU_WAY_LOCK_EN
    input  logic [WAYS-1:0] lock_mask,
`endif
    output logic            victim_valid,
    output logic [WW-1:0]   victim_way,
    output logic            victim_none
);

    logic [WAYS-2:0] tree  [SETS];
    logic [WAYS-1:0] valid [SETS];

    logic [WAYS-2:0] cur_tree, nxt_tree;
    logic [WAYS-1:0] cur_valid, nxt_valid, inv_row, elig;
    logic [WW-1:0]   inv_first, sel_way, touch_way;
    logic            any_inv, any_elig, do_touch, dir, sub_any;
    int              node_t, node_u, pfx;

    always_comb begin
        cur_tree  = tree[acc_set];
        cur_valid = valid[acc_set];
`ifdef PLRU_WAY_LOCK_EN
        elig = ~lock_mask;
`else
        elig = '1;
`endif
        any_elig  = |elig;
        any_inv   = 1'b0;
        inv_first = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (elig[i] && !cur_valid[i]) begin
                any_inv   = 1'b1;
                inv_first = WW'(i);
            end
        end

        // Walk the tree; steer around a subtree that holds no eligible way.
        node_t  = 0;
        pfx     = 0;
        dir     = 1'b0;
        sub_any = 1'b0;
        for (int l = 0; l < WW; l++) begin
            dir     = cur_tree[node_t];
            sub_any = 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                if ((i >> (WW - 1 - l)) == 2 * pfx + int'(dir))
                    sub_any = sub_any | elig[i];
            end
            if (!sub_any)
                dir = ~dir;
            pfx    = 2 * pfx + int'(dir);
            node_t = 2 * node_t + 1 + int'(dir);
        end

        sel_way   = any_inv ? inv_first : WW'(pfx);
        touch_way = acc_hit ? acc_hit_way : sel_way;
        do_touch  = acc_valid && (acc_hit || any_elig);

        nxt_tree = cur_tree;
        node_u   = 0;
        for (int l = 0; l < WW; l++) begin
            nxt_tree[node_u] = ~touch_way[WW - 1 - l];
            node_u = 2 * node_u + 1 + int'(touch_way[WW - 1 - l]);
        end

        nxt_valid = cur_valid;
        if (!acc_hit)
            nxt_valid[sel_way] = 1'b1;

        // Invalidate lands after the access so it wins on the shared valid bit.
        inv_row = (do_touch && (inv_set == acc_set)) ? nxt_valid : valid[inv_set];
        inv_row[inv_way] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                tree[s]  <= '0;
                valid[s] <= '0;
            end
            victim_valid <= 1'b0;
            victim_way   <= '0;
            victim_none  <= 1'b0;
        end else begin
            victim_valid <= acc_valid && !acc_hit;
            victim_none  <= acc_valid && !acc_hit && !any_elig;
            if (acc_valid && !acc_hit && any_elig)
                victim_way <= sel_way;
            if (do_touch) begin
                tree[acc_set]  <= nxt_tree;
                valid[acc_set] <= nxt_valid;
            end
            if (inv_valid)
                valid[inv_set] <= inv_row;
        end
    end

endmodule

// File: doc/plru_tree_nset.md
PLRU_TREE_NSET -- requirements
Module: plru_tree_nset

Interface
REQ-001 SHALL have parameter WAYS, default 16, number of ways per set (power of 2, 2..64).
REQ-002 SHALL have parameter SETS, default 4, number of independent replacement sets (power of 2, >=1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port acc_valid  input  1  access request this cycle.
REQ-006 SHALL have port acc_set  input  max(1,$clog2(SETS))  set of the access.
REQ-007 SHALL have port acc_hit  input  1  1 = hit, 0 = miss (victim requested).
REQ-008 SHALL have port acc_hit_way  input  $clog2(WAYS)  hit way; don't-care on miss.
REQ-009 SHALL have port inv_valid  input  1  invalidate request.
REQ-010 SHALL have port inv_set / inv_way  input  set width / $clog2(WAYS)  line to invalidate.
REQ-011 SHALL have port victim_valid  output  1  registered; victim_way is valid this cycle.
REQ-012 SHALL have port victim_way  output  $clog2(WAYS)  registered selected way.
REQ-013 SHALL have port victim_none  output  1  registered; miss found no eligible way.

Function
REQ-014 SHALL hold per set WAYS-1 tree bits in heap order: root node 0, children of n are 2n+1 and 2n+2, leaf-pair nodes WAYS/2-1..WAYS-2.
REQ-015 SHALL hold per set one valid bit per way.
REQ-016 Tree bit 0 SHALL mean the victim lies in the left subtree; 1 SHALL mean right.
REQ-017 SHALL, on touch of way w, set every node on w's root-to-leaf path to point away from w.
REQ-018 SHALL, on acc_valid with acc_hit=1, touch acc_hit_way at the next edge; valid bits unchanged; victim_valid stays 0.
REQ-019 SHALL, on acc_valid with acc_hit=0, select the lowest-index invalid way of acc_set if any exists; otherwise the way reached by tree traversal.
REQ-020 SHALL, on a miss, at the next edge: assert victim_valid=1 for one cycle, drive victim_way, set the victim's valid bit, and touch the victim.
REQ-021 SHALL give a miss latency of exactly 1 cycle and sustain back-to-back accesses every cycle.
REQ-022 SHALL make an access in cycle N+1 observe the state written by an access to the same set in cycle N.
REQ-023 SHALL restrict state changes to acc_set and inv_set; all other sets hold.
REQ-024 SHALL, on inv_valid, clear valid[inv_set][inv_way] at the next edge; tree bits unchanged.
REQ-025 SHALL, when an invalidate and an access hit the same set in one cycle, apply the access first and the invalidate last: the access's tree update stands, and the invalidate wins on the valid bit.
REQ-026 SHALL, on a hit to an invalid way, still perform the tree touch and leave the valid bit 0.
REQ-027 SHALL hold victim_way at its last value when victim_valid=0.

Reset
REQ-028 SHALL, while rst=1, clear all tree bits, valid bits, victim_valid, victim_way and victim_none to 0, regardless of clk.
REQ-029 SHALL discard any access in flight when rst asserts; no victim_valid pulse follows after rst deasserts.

Configuration
REQ-030 SHALL, with PLRU_WAY_LOCK_EN defined, add input lock_mask[WAYS]; locked ways are never victims.
REQ-031 With PLRU_WAY_LOCK_EN, invalid-first selection SHALL consider unlocked ways only, and traversal SHALL take the opposite child wherever the indicated subtree is fully locked.
REQ-032 With PLRU_WAY_LOCK_EN, a miss with all ways locked SHALL assert victim_valid=1 and victim_none=1 next cycle, with no state change.
REQ-033 Without PLRU_WAY_LOCK_EN, the lock_mask port SHALL be absent, all ways SHALL be eligible, and victim_none SHALL be tied 0.

Verification (WAYS=16, SETS=4)
REQ-034 After reset, 16 misses to set 2 -> victim_way 0,1,...,15, each one cycle after its request.
REQ-035 After the REQ-034 fill, a 17th miss to set 2 -> victim_way 0; alternatively, a hit on way 0 followed by a miss -> victim_way 8.
REQ-036 After the fill, inv set 2 way 5, then a miss to set 2 -> victim_way 5; the same-cycle inv+hit on way 5 -> valid bit ends 0.
REQ-037 After the fill of set 2, a miss to set 1 -> victim_way 0, and set 2 state is unchanged.
REQ-038 With PLRU_WAY_LOCK_EN and the set 2 fill: lock_mask=0x0001 and a miss -> victim_way 1; lock_mask=0xFFFF -> victim_none=1.
REQ-039 rst asserted in the cycle after a miss request -> victim_valid=0 immediately; the next miss to that set -> victim_way 0.
